// File: rtl/node_network_if_pkg.sv
// ============================================================================
// node_network_if_pkg : mesh geometry, packet format and latency helper
// Rev 1.0
// ============================================================================
`default_nettype none

package node_network_if_pkg;

    localparam int c_X_NODES   = 4;
    localparam int c_Y_NODES   = 4;
    localparam int c_NODES     = c_X_NODES * c_Y_NODES;
    localparam int c_ADDR_W    = $clog2(c_NODES);
    localparam int c_TS_W      = 16;
    localparam int c_PAYLOAD_W = 16;

    typedef struct packed {
        logic [c_ADDR_W-1:0]    source;
        logic [c_ADDR_W-1:0]    dest;
        logic [c_TS_W-1:0]      measure;
        logic [c_PAYLOAD_W-1:0] payload;
    } packet_t;

    // Modular difference, so a stamp taken just before the counter wraps still
    // yields the true elapsed cycle count.
    function automatic logic [c_TS_W-1:0] elapsed(input logic [c_TS_W-1:0] now,
                                                  input logic [c_TS_W-1:0] stamp);
        return now - stamp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/node_network_if_if.sv
// ============================================================================
// node_network_if_if : client and network handshakes of one node endpoint
// Rev 1.0
// ============================================================================
`default_nettype none

interface node_network_if_if;
    import node_network_if_pkg::*;

    packet_t client_data;
    logic    client_val;
    logic    client_ready;
    packet_t net_o_data;
    logic    net_o_val;
    logic    net_i_en;
    packet_t net_i_data;
    logic    net_i_val;
    packet_t rx_data;
    logic    rx_val;
    logic    rx_ready;

    modport master (
        output client_data, client_val, net_i_en, net_i_data, net_i_val, rx_ready,
        input  client_ready, net_o_data, net_o_val, rx_data, rx_val
    );

    modport slave (
        input  client_data, client_val, net_i_en, net_i_data, net_i_val, rx_ready,
        output client_ready, net_o_data, net_o_val, rx_data, rx_val
    );

endinterface

`default_nettype wire

// File: rtl/node_network_if_fifo.sv
// ============================================================================
// node_network_if_fifo : synchronous FIFO; push into a full FIFO is taken only
// when a pop frees the slot in the same cycle. Rev 1.0
// ============================================================================
`default_nettype none

module node_network_if_fifo
    import node_network_if_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = packet_t
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic push,
    input  wire logic pop,
    input  wire T     data_in,
    output T          data_out,
    output logic      full,
    output logic      empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    T                 r_mem [DEPTH];
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Masking the head keeps the output at zero whenever nothing is buffered.
    assign data_out  = empty ? T'('0) : r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= data_in;
    end

endmodule

`default_nettype wire

// File: rtl/node_network_if.sv
// ============================================================================
// node_network_if : node endpoint of the mesh valid/enable protocol, with
// timestamped TX buffering and RX buffering plus statistics. Rev 1.0
// ============================================================================
`default_nettype none

module node_network_if
    import node_network_if_pkg::*;
#(
    parameter int NODE_ID  = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int TS_WIDTH = 16
) (
    input  wire logic                clk,
    input  wire logic                reset,
    node_network_if_if.slave         bus,
    output logic [31:0]              tx_count,
    output logic [31:0]              rx_count,
    output logic [15:0]              rx_drop_count,
    output logic [15:0]              misroute_count,
    output logic [TS_WIDTH-1:0]      max_latency
);

    localparam logic [c_ADDR_W-1:0] c_SELF = c_ADDR_W'(NODE_ID);

    logic [TS_WIDTH-1:0] r_cycle;
    packet_t             w_tx_in;
    packet_t             w_tx_head;
    packet_t             w_rx_head;
    logic                w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
    logic                w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
    logic                w_drop, w_misroute;
    logic [TS_WIDTH-1:0] w_lat;

    always_comb begin
        w_tx_in         = bus.client_data;
        w_tx_in.source  = c_SELF;
        w_tx_in.measure = c_TS_W'(r_cycle);
    end

    // Ready is held low for as long as reset is asserted.
    assign bus.client_ready = !reset && !w_tx_full;
    assign w_tx_push        = bus.client_val && !reset && !w_tx_full;
    assign w_tx_pop         = !w_tx_empty && bus.net_i_en;
    assign bus.net_o_val    = !w_tx_empty;
    assign bus.net_o_data   = w_tx_head;

    assign w_rx_pop         = !w_rx_empty && bus.rx_ready;
    assign w_rx_push        = bus.net_i_val && (!w_rx_full || w_rx_pop);
    assign w_drop           = bus.net_i_val && !w_rx_push;
    assign w_misroute       = bus.net_i_val && (bus.net_i_data.dest != c_SELF);
    assign w_lat            = TS_WIDTH'(elapsed(c_TS_W'(r_cycle), bus.net_i_data.measure));
    assign bus.rx_val       = !w_rx_empty;
    assign bus.rx_data      = w_rx_head;

    node_network_if_fifo #(.DEPTH(TX_DEPTH), .T(packet_t)) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_tx_push),
        .pop      (w_tx_pop),
        .data_in  (w_tx_in),
        .data_out (w_tx_head),
        .full     (w_tx_full),
        .empty    (w_tx_empty)
    );

    node_network_if_fifo #(.DEPTH(RX_DEPTH), .T(packet_t)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_rx_push),
        .pop      (w_rx_pop),
        .data_in  (bus.net_i_data),
        .data_out (w_rx_head),
        .full     (w_rx_full),
        .empty    (w_rx_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle        <= '0;
            tx_count       <= '0;
            rx_count       <= '0;
            rx_drop_count  <= '0;
            misroute_count <= '0;
            max_latency    <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (w_tx_pop)  tx_count <= tx_count + 1'b1;
            if (w_rx_push) rx_count <= rx_count + 1'b1;
            if (w_drop && (rx_drop_count != 16'hFFFF))
                rx_drop_count <= rx_drop_count + 1'b1;
            if (w_misroute && (misroute_count != 16'hFFFF))
                misroute_count <= misroute_count + 1'b1;
            if (w_rx_push && (w_lat > max_latency))
                max_latency <= w_lat;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_node_network_if.sv
// ============================================================================
// tb_node_network_if : directed stimulus with queue scoreboards for the TX and
// RX paths of node_network_if. Rev 1.0
// ============================================================================
`default_nettype none

module tb_node_network_if;
    import node_network_if_pkg::*;

    localparam int c_NODE_ID = 5;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] tx_count, rx_count;
    logic [15:0] rx_drop_count, misroute_count, max_latency;

    node_network_if_if bus ();

    node_network_if #(
        .NODE_ID  (c_NODE_ID),
        .TX_DEPTH (4),
        .RX_DEPTH (4),
        .TS_WIDTH (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .tx_count       (tx_count),
        .rx_count       (rx_count),
        .rx_drop_count  (rx_drop_count),
        .misroute_count (misroute_count),
        .max_latency    (max_latency)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    packet_t     tx_exp[$];
    packet_t     rx_exp[$];
    logic [15:0] model_cyc;

    always @(posedge clk or posedge reset) begin
        if (reset) model_cyc <= '0;
        else       model_cyc <= model_cyc + 16'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic packet_t mk(input logic [3:0] src, input logic [3:0] dst,
                                   input logic [15:0] meas, input logic [15:0] pay);
        packet_t p;
        p.source  = src;
        p.dest    = dst;
        p.measure = meas;
        p.payload = pay;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a transfer is checked in the cycle it is presented.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.net_o_val && bus.net_i_en) begin
                if (tx_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=%0h required=none", bus.net_o_data);
                end else begin
                    check("tx_pkt", 64'(bus.net_o_data), 64'(tx_exp.pop_front()));
                end
            end
            if (bus.rx_val && bus.rx_ready) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%0h required=none", bus.rx_data);
                end else begin
                    check("rx_pkt", 64'(bus.rx_data), 64'(rx_exp.pop_front()));
                end
            end
        end
    end

    task automatic send_tx(input logic [15:0] pay);
        packet_t p;
        bus.client_data = mk(4'hA, 4'd2, 16'hBEEF, pay);
        bus.client_val  = 1'b1;
        p         = bus.client_data;
        p.source  = 4'(c_NODE_ID);
        p.measure = model_cyc;
        tx_exp.push_back(p);
    endtask

    task automatic deliver(input logic [3:0] dst, input logic [15:0] meas,
                           input logic [15:0] pay, input bit accepted);
        bus.net_i_data = mk(4'h1, dst, meas, pay);
        bus.net_i_val  = 1'b1;
        if (accepted) rx_exp.push_back(bus.net_i_data);
    endtask

    task automatic drain_rx();
        bus.net_i_val = 1'b0;
        bus.rx_ready  = 1'b1;
        repeat (5) tick();
        bus.rx_ready  = 1'b0;
        check("rx_drained", 64'(rx_exp.size()), 64'd0);
    endtask

    initial begin
        bit reached;
        bus.client_data = '0;
        bus.client_val  = 1'b0;
        bus.net_i_en    = 1'b0;
        bus.net_i_data  = '0;
        bus.net_i_val   = 1'b0;
        bus.rx_ready    = 1'b0;

        repeat (2) tick();
        check("rst_client_ready", 64'(bus.client_ready), 64'd0);
        check("rst_net_o_val", 64'(bus.net_o_val), 64'd0);
        check("rst_rx_val", 64'(bus.rx_val), 64'd0);
        check("rst_net_o_data", 64'(bus.net_o_data), 64'd0);
        check("rst_tx_count", 64'(tx_count), 64'd0);
        check("rst_max_latency", 64'(max_latency), 64'd0);
        reset = 1'b0;
        tick();
        check("ready_after_rst", 64'(bus.client_ready), 64'd1);

        // Basic TX: three back-to-back packets with the network enabled.
        bus.net_i_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_tx(16'h1000 + 16'(i));
            if (i == 0) check("tx_no_bypass", 64'(bus.net_o_val), 64'd0);
            tick();
            check("tx_val_run", 64'(bus.net_o_val), 64'd1);
        end
        bus.client_val = 1'b0;
        tick();
        check("tx_val_end", 64'(bus.net_o_val), 64'd0);
        check("tx_count_basic", 64'(tx_count), 64'd3);

        // TX stall: fill the FIFO while the network refuses.
        bus.net_i_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_tx(16'h2000 + 16'(i));
            tick();
        end
        check("tx_full_ready", 64'(bus.client_ready), 64'd0);
        bus.client_data = mk(4'hA, 4'd2, 16'hBEEF, 16'h2FFF);
        bus.client_val  = 1'b1;
        tick();
        tick();
        check("stall_val", 64'(bus.net_o_val), 64'd1);
        check("stall_head", 64'(bus.net_o_data), 64'(tx_exp[0]));
        check("stall_ready", 64'(bus.client_ready), 64'd0);
        bus.client_val = 1'b0;
        bus.net_i_en   = 1'b1;
        repeat (5) tick();
        check("tx_count_stall", 64'(tx_count), 64'd7);
        check("tx_sb_empty", 64'(tx_exp.size()), 64'd0);
        bus.net_i_en = 1'b0;

        // RX overflow: six deliveries into a four-entry FIFO nobody drains.
        for (int i = 0; i < 6; i++) begin
            deliver(4'(c_NODE_ID), 16'(model_cyc - 16'd3), 16'h3000 + 16'(i), i < 4);
            tick();
        end
        bus.net_i_val = 1'b0;
        check("ovf_rx_count", 64'(rx_count), 64'd4);
        check("ovf_drop", 64'(rx_drop_count), 64'd2);
        check("ovf_max_lat", 64'(max_latency), 64'd3);
        check("ovf_rx_val", 64'(bus.rx_val), 64'd1);
        drain_rx();

        // Full FIFO with a simultaneous pop accepts the new packet.
        for (int i = 0; i < 4; i++) begin
            deliver(4'(c_NODE_ID), 16'(model_cyc - 16'd3), 16'h4000 + 16'(i), 1'b1);
            tick();
        end
        deliver(4'(c_NODE_ID), 16'(model_cyc - 16'd3), 16'h4004, 1'b1);
        bus.rx_ready = 1'b1;
        tick();
        bus.net_i_val = 1'b0;
        bus.rx_ready  = 1'b0;
        check("popfull_drop", 64'(rx_drop_count), 64'd2);
        check("popfull_rx_count", 64'(rx_count), 64'd9);
        drain_rx();

        // Misroute on a full FIFO, then misroute on an accepted packet.
        for (int i = 0; i < 4; i++) begin
            deliver(4'(c_NODE_ID), 16'(model_cyc - 16'd3), 16'h5000 + 16'(i), 1'b1);
            tick();
        end
        deliver(4'd3, 16'(model_cyc - 16'd3), 16'h5004, 1'b0);
        tick();
        bus.net_i_val = 1'b0;
        check("mis_count_drop", 64'(misroute_count), 64'd1);
        check("mis_drop", 64'(rx_drop_count), 64'd3);
        check("mis_rx_count", 64'(rx_count), 64'd13);
        drain_rx();
        deliver(4'd3, 16'(model_cyc - 16'd3), 16'h5005, 1'b1);
        tick();
        bus.net_i_val = 1'b0;
        check("mis_count_acc", 64'(misroute_count), 64'd2);
        check("mis_rx_count_acc", 64'(rx_count), 64'd14);
        drain_rx();

        // Reset with 2 TX and 3 RX packets queued.
        for (int i = 0; i < 3; i++) begin
            if (i < 2) send_tx(16'h6000 + 16'(i));
            else       bus.client_val = 1'b0;
            deliver(4'(c_NODE_ID), 16'(model_cyc - 16'd3), 16'h6100 + 16'(i), 1'b1);
            tick();
        end
        bus.client_val = 1'b0;
        bus.net_i_val  = 1'b0;
        check("pre_rst_tx_val", 64'(bus.net_o_val), 64'd1);
        check("pre_rst_rx_val", 64'(bus.rx_val), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_net_o_val", 64'(bus.net_o_val), 64'd0);
        check("arst_rx_val", 64'(bus.rx_val), 64'd0);
        check("arst_rx_data", 64'(bus.rx_data), 64'd0);
        check("arst_tx_count", 64'(tx_count), 64'd0);
        check("arst_rx_count", 64'(rx_count), 64'd0);
        check("arst_drop", 64'(rx_drop_count), 64'd0);
        check("arst_misroute", 64'(misroute_count), 64'd0);
        check("arst_client_ready", 64'(bus.client_ready), 64'd0);
        tx_exp.delete();
        rx_exp.delete();
        tick();
        reset        = 1'b0;
        bus.net_i_en = 1'b1;
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_tx_idle", 64'(bus.net_o_val), 64'd0);
            check("post_rst_rx_idle", 64'(bus.rx_val), 64'd0);
        end

        // Latency across the counter wrap, then a smaller latency.
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (model_cyc == 16'h0010) reached = 1'b1;
            else tick();
        end
        if (!reached) begin
            checks++;
            failures++;
            $display("FAIL wait_cycle16 actual=%0h required=10", model_cyc);
        end
        deliver(4'(c_NODE_ID), 16'hFFF0, 16'h7000, 1'b1);
        tick();
        bus.net_i_val = 1'b0;
        check("lat_wrap", 64'(max_latency), 64'h20);
        deliver(4'(c_NODE_ID), 16'(model_cyc - 16'd5), 16'h7001, 1'b1);
        tick();
        bus.net_i_val = 1'b0;
        tick();
        check("lat_keep", 64'(max_latency), 64'h20);
        check("lat_rx_sb_empty", 64'(rx_exp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
